handshake_fifo_syn: RTL and testbench



---
 rtl/handshake_fifo_syn.sv | 168 ++++++++++++++++
 tb/tb_handshake_fifo_syn.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_fifo_syn.sv
// handshake_fifo_syn: word stream from sclk to dclk through a source FIFO
// and a 4-phase (MODE 0) or 2-phase (MODE 1) req/ack crossing.
`timescale 1ns/1ps
module handshake_fifo_syn #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       sclk,
  input  logic                       dclk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  input  logic [WIDTH-1:0]           s_data,
  output logic                       s_ready,
  output logic [$clog2(DEPTH+1)-1:0] s_count,
  output logic                       s_idle,
  output logic                       d_valid,
  output logic [WIDTH-1:0]           d_data,
  input  logic                       d_ready
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_REL
  } st_e;

  st_e              state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             sreq_q, sreq_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic             dack_q, dack_d;
  logic             d_valid_q, d_valid_d;
  logic [WIDTH-1:0] d_data_q, d_data_d;
  logic             sack, dreq, new_req;
  logic             push, pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign sack    = ack_sync_q[SYNC_STAGES-1];
  assign dreq    = req_sync_q[SYNC_STAGES-1];
  assign s_ready = count_q < CW'(DEPTH);
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == ST_IDLE) && (count_q != '0);
  assign s_count = count_q;
  assign s_idle  = (count_q == '0) && (state_q == ST_IDLE);
  assign d_valid = d_valid_q;
  assign d_data  = d_data_q;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = s_data;
      wptr_d        = wrap_inc(wptr_q);
    end
    if (pop) rptr_d = wrap_inc(rptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (pop) state_d = ST_REQ;
      ST_REQ: begin
        if (MODE == 0) begin
          if (sack) state_d = ST_WAIT_REL;
        end else if (sack == sreq_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_REL: if (!sack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // hold_q only changes on launch, so dclk may sample it once dreq arrives
  always_comb begin
    sreq_d = sreq_q;
    hold_d = hold_q;
    if (pop) begin
      hold_d = mem_q[rptr_q];
      sreq_d = (MODE == 0) ? 1'b1 : ~sreq_q;
    end else if (MODE == 0 && state_q == ST_REQ && sack) begin
      sreq_d = 1'b0;
    end
  end

  always_comb begin
    req_sync_d = {req_sync_q[SYNC_STAGES-2:0], sreq_q};
    ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], dack_q};
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      sreq_q     <= 1'b0;
      ack_sync_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      hold_q     <= hold_d;
      sreq_q     <= sreq_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign new_req = (MODE == 0) ? (dreq && !dack_q) : (dreq != dack_q);

  // ack only after the consumer takes the word: backpressure stalls the launcher
  always_comb begin
    d_valid_d = d_valid_q;
    d_data_d  = d_data_q;
    dack_d    = dack_q;
    if (d_valid_q) begin
      if (d_ready) begin
        d_valid_d = 1'b0;
        dack_d    = (MODE == 0) ? 1'b1 : dreq;
      end
    end else if (new_req) begin
      d_valid_d = 1'b1;
      d_data_d  = hold_q;
    end else if (MODE == 0 && !dreq) begin
      dack_d = 1'b0;
    end
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      dack_q     <= 1'b0;
      d_valid_q  <= 1'b0;
      d_data_q   <= '0;
    end else begin
      req_sync_q <= req_sync_d;
      dack_q     <= dack_d;
      d_valid_q  <= d_valid_d;
      d_data_q   <= d_data_d;
    end
  end

endmodule

// File: tb/tb_handshake_fifo_syn.sv
// tb_handshake_fifo_syn: four instances (MODE0/1, DEPTH 4/4/3/1) driven
// with shared directed stimulus; per-instance scoreboards check delivery.
`timescale 1ns/1ps
module tb_handshake_fifo_syn;
  localparam int W = 32;
  localparam int N = 4;

  logic         sclk = 1'b0;
  logic         dclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         d_ready = 1'b1;
  logic [W-1:0] s_data = '0;
  logic [N-1:0] s_ready, s_idle, d_valid;
  logic [2:0]   s_count [N];
  logic [W-1:0] d_data [N];
  int           acc [N];
  int           dlv [N];
  logic [W-1:0] last [N];
  realtime      tlast [N];
  int           ea [N];
  int           n_chk = 0;
  int           n_fail = 0;
  realtime      dh = 8.5;

  always #5 sclk = ~sclk;
  initial begin
    #0.3;
    forever #(dh) dclk = ~dclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : gi
    localparam int DP = (g == 2) ? 3 : (g == 3) ? 1 : 4;
    localparam int MD = g % 2;
    logic [$clog2(DP+1)-1:0] cnt;
    logic [W-1:0] q [$];

    handshake_fifo_syn #(
      .WIDTH(W), .DEPTH(DP), .MODE(MD), .SYNC_STAGES(2)
    ) dut (
      .sclk(sclk), .dclk(dclk), .rst_n(rst_n),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready[g]),
      .s_count(cnt), .s_idle(s_idle[g]),
      .d_valid(d_valid[g]), .d_data(d_data[g]), .d_ready(d_ready)
    );

    assign s_count[g] = 3'(cnt);

    initial forever begin
      @(posedge sclk);
      if (!rst_n) begin
        q.delete();
        acc[g] = 0;
      end else if (s_valid && s_ready[g]) begin
        q.push_back(s_data);
        acc[g]++;
      end
    end

    initial forever begin
      @(posedge dclk);
      if (!rst_n) begin
        dlv[g] = 0;
      end else if (d_valid[g] && d_ready) begin
        dlv[g]++;
        last[g] = d_data[g];
        tlast[g] = $realtime;
        chk($sformatf("dut%0d_word_expected", g), 64'(q.size() != 0), 64'd1);
        if (q.size() != 0)
          chk($sformatf("dut%0d_order", g), 64'(d_data[g]), 64'(q.pop_front()));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      acc[i] = 0;
      dlv[i] = 0;
    end
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while (!((&s_idle) && d_valid == '0) && n < maxc) begin
      cyc();
      n++;
    end
    chk({tag, "_drained"}, 64'(n < maxc), 64'd1);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_dlv%0d", tag, i), 64'(dlv[i]), 64'(acc[i]));
  endtask

  task automatic reset_vals(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_count%0d", tag, i), 64'(s_count[i]), 64'd0);
      chk($sformatf("%s_idle%0d", tag, i), 64'(s_idle[i]), 64'd1);
      chk($sformatf("%s_ready%0d", tag, i), 64'(s_ready[i]), 64'd1);
      chk($sformatf("%s_dvalid%0d", tag, i), 64'(d_valid[i]), 64'd0);
      chk($sformatf("%s_ddata%0d", tag, i), 64'(d_data[i]), 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      last[i] = '0;
      tlast[i] = 0;
    end
    cyc(3);
    reset_vals("rst");
    rst_n = 1'b1;
    cyc(2);

    // back-to-back burst, consumer always ready
    clr();
    for (int w = 1; w <= 4; w++) begin
      s_valid = 1'b1;
      s_data = 32'hA5A5_0000 + W'(w);
      cyc();
    end
    s_valid = 1'b0;
    drain("burst", 600);
    ea = '{4, 4, 4, 2};
    for (int i = 0; i < N; i++)
      chk($sformatf("burst_acc%0d", i), 64'(acc[i]), 64'(ea[i]));
    chk("burst_last0", 64'(last[0]), 64'h0000_0000_A5A5_0004);
    chk("burst_last3", 64'(last[3]), 64'h0000_0000_A5A5_0003);
    chk("mode1_faster", 64'(tlast[1] < tlast[0]), 64'd1);

    // backpressure: six offers against a stalled consumer
    clr();
    d_ready = 1'b0;
    for (int w = 1; w <= 6; w++) begin
      s_valid = 1'b1;
      s_data = 32'hB000_0000 + W'(w);
      cyc();
    end
    s_valid = 1'b0;
    cyc(40);
    ea = '{4, 4, 3, 1};
    for (int i = 0; i < N; i++) begin
      chk($sformatf("bp_count%0d", i), 64'(s_count[i]), 64'(ea[i]));
      chk($sformatf("bp_ready%0d", i), 64'(s_ready[i]), 64'd0);
      chk($sformatf("bp_dvalid%0d", i), 64'(d_valid[i]), 64'd1);
      chk($sformatf("bp_ddata%0d", i), 64'(d_data[i]), 64'h0000_0000_B000_0001);
    end
    ea = '{5, 5, 4, 2};
    for (int i = 0; i < N; i++)
      chk($sformatf("bp_acc%0d", i), 64'(acc[i]), 64'(ea[i]));
    d_ready = 1'b1;
    drain("bp", 2000);
    chk("bp_last0", 64'(last[0]), 64'h0000_0000_B000_0005);
    chk("bp_last1", 64'(last[1]), 64'h0000_0000_B000_0005);
    chk("bp_last2", 64'(last[2]), 64'h0000_0000_B000_0004);
    chk("bp_last3", 64'(last[3]), 64'h0000_0000_B000_0003);

    // push then push+pop at count==1
    clr();
    s_valid = 1'b1;
    s_data = 32'h0000_00C1;
    cyc();
    for (int i = 0; i < N; i++)
      chk($sformatf("pp1_count%0d", i), 64'(s_count[i]), 64'd1);
    s_data = 32'h0000_00C2;
    cyc();
    s_valid = 1'b0;
    ea = '{1, 1, 1, 0};
    for (int i = 0; i < N; i++)
      chk($sformatf("pp2_count%0d", i), 64'(s_count[i]), 64'(ea[i]));
    drain("pp", 600);

    // ten words with random gaps
    clr();
    for (int w = 0; w < 10; w++) begin
      s_valid = 1'b1;
      s_data = $urandom;
      cyc();
      s_valid = 1'b0;
      cyc($urandom_range(0, 12));
    end
    drain("gap", 2000);
    chk("gap_acc0_nonzero", 64'(acc[0] > 0), 64'd1);
    chk("gap_acc3_nonzero", 64'(acc[3] > 0), 64'd1);

    // reset while a word is presented and the launcher waits
    clr();
    d_ready = 1'b0;
    s_valid = 1'b1;
    s_data = 32'h0000_00D1;
    cyc();
    s_data = 32'h0000_00D2;
    cyc();
    s_valid = 1'b0;
    cyc(40);
    chk("pre_rst_dvalid", 64'(d_valid), 64'hF);
    chk("pre_rst_busy", 64'(s_idle), 64'h0);
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    cyc(5);
    rst_n = 1'b1;
    d_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk("no_spurious_dvalid", 64'(d_valid), 64'h0);
    end
    s_valid = 1'b1;
    s_data = 32'h0000_005A;
    cyc();
    s_valid = 1'b0;
    drain("post_rst", 600);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("post_rst_n%0d", i), 64'(dlv[i]), 64'd1);
      chk($sformatf("post_rst_data%0d", i), 64'(last[i]), 64'h5A);
    end

    // clock-ratio sweep with random valid and ready
    for (int r = 0; r < 3; r++) begin
      clr();
      dh = (r == 0) ? 25.0 : (r == 1) ? 5.0 : 1.0;
      for (int k = 0; k < 500; k++) begin
        s_valid = ($urandom_range(0, 3) == 0);
        s_data = $urandom;
        d_ready = 1'($urandom_range(0, 1));
        cyc();
      end
      s_valid = 1'b0;
      d_ready = 1'b1;
      drain($sformatf("sweep%0d", r), 6000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
